// File: rtl/vga_timing_ctrl.sv
// Raster timing generator for the 640x480@60 display path: counters, position
// outputs, a sync/DE delay line matched to the pixel generator, and the output register.
module vga_timing_ctrl #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_POL    = 1'b0,
  parameter int PIC_LATENCY = 1
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  input  logic [23:0] pos_data,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        frame_tick
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic       SYNC_IDLE = ~SYNC_POL;

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       de_raw;
  logic       hs_raw;
  logic       vs_raw;
  logic [2:0] ctl_p1 [PIC_LATENCY];
  logic [2:0] ctl_d;
  logic       unused_low;

  function automatic logic [11:0] to_rgb12(input logic [3:0] r, input logic [3:0] g,
                                           input logic [3:0] b);
    return {r, g, b};
  endfunction

  // Stage p0: raster counters
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Position is held at 0,0 while in reset so the generator sees blanking.
  assign de_raw = rst_n && (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_raw = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_raw = (v_cnt >= VS_START) && (v_cnt < VS_END);
  assign pos_x  = de_raw ? h_cnt : '0;
  assign pos_y  = de_raw ? v_cnt + 10'd1 : '0;

  // Stage p1: control delay line matching the generator latency
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIC_LATENCY; i++) ctl_p1[i] <= 3'b000;
    end else begin
      ctl_p1[0] <= {de_raw, hs_raw, vs_raw};
      for (int i = 1; i < PIC_LATENCY; i++) ctl_p1[i] <= ctl_p1[i-1];
    end
  end

  assign ctl_d      = ctl_p1[PIC_LATENCY-1];
  assign unused_low = ^{pos_data[19:16], pos_data[11:8], pos_data[3:0]};

  // Stage p2: output register; frame_tick bypasses the delay line on purpose
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb        <= '0;
      hsync      <= SYNC_IDLE;
      vsync      <= SYNC_IDLE;
      frame_tick <= 1'b0;
    end else begin
      rgb        <= ctl_d[2] ? to_rgb12(pos_data[23:20], pos_data[15:12], pos_data[7:4])
                             : 12'h000;
      hsync      <= ctl_d[1] ^ SYNC_IDLE;
      vsync      <= ctl_d[0] ^ SYNC_IDLE;
      frame_tick <= (h_cnt == '0) && (v_cnt == V_ACT);
    end
  end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Raster timing generator and output stage for the 640x480@60 Hz display path. It drives `pos_x`/`pos_y` into the falling-block pixel generator and takes that block's registered 24-bit `pos_data` back. It emits `hsync`/`vsync` and 12-bit RGB to the board connector, delayed so that sync, blanking and pixel data stay cycle-aligned. It also gives the rest of the design a once-per-frame tick.

## Interface
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in clocks.
- `H_SYNC`, 96: hsync pulse width, in clocks.
- `H_BP`, 48: horizontal back porch, in clocks.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `SYNC_POL`, 0: sync polarity. 0 means active-low; 1 means active-high.
- `PIC_LATENCY`, 1: clock cycles from `pos_x`/`pos_y` to valid `pos_data`. Legal range is 1..4.

Ports:
- `vga_clk`, in, 1: 25 MHz pixel clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `pos_data`, in, 24: pixel from the generator, `{R[7:0], G[7:0], B[7:0]}`.
- `pos_x`, out, 10: current column. Range 0..639 during the active region, 0 during blanking.
- `pos_y`, out, 10: current row, 1-based. Range 1..480 during the active region, 0 during blanking.
- `hsync`, out, 1: horizontal sync, with polarity set by `SYNC_POL`.
- `vsync`, out, 1: vertical sync, with polarity set by `SYNC_POL`.
- `rgb`, out, 12: `{R[7:4], G[7:4], B[7:4]}`.
- `frame_tick`, out, 1: one-cycle pulse at the start of vertical blanking.

## Operation
- **Horizontal counter.** `h_cnt` runs 0..H_TOT-1 and wraps to 0, where H_TOT = `H_ACTIVE + H_FP + H_SYNC + H_BP` (800).
- **Vertical counter.** `v_cnt` runs 0..V_TOT-1, where V_TOT = 525. It increments only when `h_cnt` = H_TOT-1, and wraps to 0 when that happens with `v_cnt` = V_TOT-1.
- **Horizontal regions.**
  - Active: 0..639.
  - Front porch: 640..655.
  - Sync: 656..751.
  - Back porch: 752..799.
- **Vertical regions.**
  - Active: 0..479.
  - Front porch: 480..489.
  - Sync: 490..491.
  - Back porch: 492..524.
- **Raw control signals**, combinational from the counters:
  - `de_raw` = (`h_cnt` < 640) && (`v_cnt` < 480).
  - `hs_raw` = `h_cnt` in sync region; `vs_raw` = `v_cnt` in sync region. Both are active-true at this point.
- **Position outputs.** `pos_x` = `de_raw` ? `h_cnt` : 0. `pos_y` = `de_raw` ? `v_cnt`+1 : 0. Both are combinational from the counter registers and glitch-free only at clock edges.
- **Delay line.** `{de, hs, vs}` passes through a shift register of depth `PIC_LATENCY`.
- **Output register.** The final stage registers all outputs together:
  - `rgb` = `de_d` ? `{pos_data[23:20], pos_data[15:12], pos_data[7:4]}` : 12'h000.
  - `hsync` = `hs_d` ^ ~`SYNC_POL`; `vsync` = `vs_d` ^ ~`SYNC_POL`.
- **Blanking rule.** Whenever the delayed DE is 0, `pos_data` is ignored and `rgb` is forced to 0.
- **Frame tick.** `frame_tick` is registered and is 1 for exactly one cycle following the edge where `h_cnt` = 0 and `v_cnt` = 480. It is not delayed by `PIC_LATENCY`.
- **Reset**, asynchronous, effective immediately:
  - `h_cnt` = `v_cnt` = 0.
  - Delay line cleared to de=0 and sync inactive.
  - `rgb` = 0, `frame_tick` = 0, `hsync`/`vsync` at the inactive level (1 for the default polarity).
- **Reset mid-frame.** Counters restart at 0,0. No partial sync pulse may appear after release.

## Timing
- Cycle 0 is the first rising edge after `rst_n` deasserts, with counters at (0,0). `pos_x`/`pos_y` are valid in the same cycle as the counter values.
- **Output latency.** `rgb`, `hsync` and `vsync` lag the counter state by `PIC_LATENCY`+1 cycles (2 at default).
- **hsync.** With the default latency, `hsync` is low for `h_cnt` equivalents 658..753: 96 consecutive cycles out of every 800.
- **vsync.** `vsync` is active for exactly 2×800 = 1600 cycles per 420000-cycle frame. It begins aligned with `hsync`-region timing plus the pipeline delay, at line 490.
- **Line boundary.** When the counter is at `h_cnt` = 799, `v_cnt` = 524, the next counter state is (0,0). There are no stall or skip states.
- **Simultaneous wrap.** When both counters wrap on the same edge, `frame_tick` is not asserted.

## Test plan
1. **Reset values.** Hold `rst_n`=0 for 10 cycles. Expect `hsync`=`vsync`=1, `rgb`=0, `frame_tick`=0, `pos_x`=`pos_y`=0. Release `rst_n`. Expect `pos_x`=0 and `pos_y`=1 at cycle 0.
2. **Horizontal timing.** Run 3 lines. Expect `hsync` falling edges exactly 800 cycles apart, each low pulse exactly 96 cycles, and the first fall at cycle 658.
3. **Frame timing.** Run 2 frames. Expect `frame_tick` pulses exactly 420000 cycles apart, with the first at cycle 480×800+1. Expect each `vsync` low pulse to last 1600 cycles.
4. **Pixel alignment.** Use a model that drives `pos_data` = `{pos_x[7:0], pos_y[7:0], 8'hA5}` registered with 1-cycle latency. Expect `rgb` two cycles after a given counter state to equal `{x[7:4], y[7:4], 4'hA}`. Expect `rgb`=0 for all blanking cycles.
5. **Blanking.** Force `pos_data`=24'hFFFFFF. Expect `rgb`=12'hFFF only during the 640 cycles per active line, and 0 for all of lines 480..524.
6. **Mid-frame reset.** Assert `rst_n`=0 at line 200, column 300, for 3 cycles. Expect outputs to return immediately to reset values. After release, expect the timing of scenario 2 to restart from cycle 0.
